// File: rtl/outpkt_arbiter_bcrypt.sv
// outpkt_arbiter_bcrypt: shares the bcrypt output-packet formatter
// between N_SRC result sources (round-robin) and one PACKET_DONE requester.
`ifndef OUTPKT_TYPE_MSB
`define OUTPKT_TYPE_MSB 1
`endif
`ifndef OUTPKT_TYPE_RESULT
`define OUTPKT_TYPE_RESULT 2'd1
`endif
`ifndef OUTPKT_TYPE_CMP_RESULT
`define OUTPKT_TYPE_CMP_RESULT 2'd2
`endif
`ifndef OUTPKT_TYPE_PACKET_DONE
`define OUTPKT_TYPE_PACKET_DONE 2'd3
`endif

module outpkt_arbiter_bcrypt #(
  parameter int N_SRC = 4,
  parameter int PKT_TYPE_MSB = `OUTPKT_TYPE_MSB,
  parameter int HASH_NUM_MSB = 15
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [N_SRC-1:0]                  res_ready,
  input  logic [N_SRC-1:0]                  res_cmp,
  input  logic [N_SRC*16-1:0]               res_pkt_id,
  input  logic [N_SRC*(HASH_NUM_MSB+1)-1:0] res_hash_num,
  input  logic [N_SRC*16-1:0]               src_din,
  output logic [3:0]                        src_rd_addr,
  output logic [N_SRC-1:0]                  res_ack,
  input  logic                              done_req,
  input  logic [15:0]                       done_pkt_id,
  input  logic [31:0]                       done_num_processed,
  output logic                              done_ack,
  output logic                              source_not_empty,
  input  logic                              full,
  input  logic [3:0]                        rd_addr,
  output logic [15:0]                       din,
  output logic                              wr_en,
  output logic [PKT_TYPE_MSB:0]             pkt_type,
  output logic [15:0]                       pkt_id,
  output logic [HASH_NUM_MSB:0]             hash_num,
  output logic [31:0]                       num_processed
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int HW = HASH_NUM_MSB + 1;
  localparam int TW = PKT_TYPE_MSB + 1;

  localparam logic [TW-1:0] T_RES  = TW'(`OUTPKT_TYPE_RESULT);
  localparam logic [TW-1:0] T_CMP  = TW'(`OUTPKT_TYPE_CMP_RESULT);
  localparam logic [TW-1:0] T_DONE = TW'(`OUTPKT_TYPE_PACKET_DONE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACK
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     grant_idx_q, grant_idx_d;
  logic              grant_done_q, grant_done_d;
  logic              sne_q, sne_d;
  logic              wr_en_q, wr_en_d;
  logic [N_SRC-1:0]  res_ack_q, res_ack_d;
  logic              done_ack_q, done_ack_d;
  logic [TW-1:0]     pkt_type_q, pkt_type_d;
  logic [15:0]       pkt_id_q, pkt_id_d;
  logic [HW-1:0]     hash_q, hash_d;
  logic [31:0]       nproc_q, nproc_d;

  logic              rr_hit;
  logic [IW-1:0]     rr_win;
  logic              win_cmp;
  logic [15:0]       win_id;
  logic [HW-1:0]     win_hash;
  logic [15:0]       din_mux;
  logic [IW-1:0]     rr_next;

  // Round-robin search: first ready source at or above rr_ptr, wrapping.
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    j      = 0;
    jj     = '0;
    rr_hit = 1'b0;
    rr_win = '0;
    for (int k = 0; k < N_SRC; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_SRC) j = j - N_SRC;
      jj = IW'(j);
      if (!rr_hit && res_ready[jj]) begin
        rr_hit = 1'b1;
        rr_win = jj;
      end
    end
  end

  always_comb begin
    win_cmp  = 1'b0;
    win_id   = '0;
    win_hash = '0;
    din_mux  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (rr_win == IW'(i)) begin
        win_cmp  = res_cmp[i];
        win_id   = res_pkt_id[16*i +: 16];
        win_hash = res_hash_num[HW*i +: HW];
      end
      if (grant_idx_q == IW'(i)) begin
        din_mux = src_din[16*i +: 16];
      end
    end
  end

  assign rr_next = (grant_idx_q == IW'(N_SRC - 1))
                 ? '0 : grant_idx_q + IW'(1);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_idx_d  = grant_idx_q;
    grant_done_d = grant_done_q;
    sne_d        = sne_q;
    wr_en_d      = 1'b0;
    res_ack_d    = '0;
    done_ack_d   = 1'b0;
    pkt_type_d   = pkt_type_q;
    pkt_id_d     = pkt_id_q;
    hash_d       = hash_q;
    nproc_d      = nproc_q;
    unique case (state_q)
      S_IDLE: begin
        // Results always win over DONE so DONE never overtakes them.
        if (rr_hit) begin
          state_d      = S_BUSY;
          grant_idx_d  = rr_win;
          grant_done_d = 1'b0;
          pkt_type_d   = win_cmp ? T_CMP : T_RES;
          pkt_id_d     = win_id;
          hash_d       = win_cmp ? win_hash : '0;
          nproc_d      = '0;
          sne_d        = 1'b1;
        end else if (done_req) begin
          state_d      = S_BUSY;
          grant_idx_d  = '0;
          grant_done_d = 1'b1;
          pkt_type_d   = T_DONE;
          pkt_id_d     = done_pkt_id;
          hash_d       = '0;
          nproc_d      = done_num_processed;
          sne_d        = 1'b1;
        end
      end
      S_BUSY: begin
        if (!full) begin
          state_d = S_ACK;
          wr_en_d = 1'b1;
          sne_d   = 1'b0;
          if (grant_done_q) begin
            done_ack_d = 1'b1;
          end else begin
            res_ack_d = N_SRC'(1) << grant_idx_q;
            rr_ptr_d  = rr_next;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_idx_q  <= '0;
      grant_done_q <= 1'b0;
      sne_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      res_ack_q    <= '0;
      done_ack_q   <= 1'b0;
      pkt_type_q   <= '0;
      pkt_id_q     <= '0;
      hash_q       <= '0;
      nproc_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_idx_q  <= grant_idx_d;
      grant_done_q <= grant_done_d;
      sne_q        <= sne_d;
      wr_en_q      <= wr_en_d;
      res_ack_q    <= res_ack_d;
      done_ack_q   <= done_ack_d;
      pkt_type_q   <= pkt_type_d;
      pkt_id_q     <= pkt_id_d;
      hash_q       <= hash_d;
      nproc_q      <= nproc_d;
    end
  end

  assign src_rd_addr      = rd_addr;
  assign din              = grant_done_q ? 16'h0 : din_mux;
  assign source_not_empty = sne_q;
  assign wr_en            = wr_en_q;
  assign res_ack          = res_ack_q;
  assign done_ack         = done_ack_q;
  assign pkt_type         = pkt_type_q;
  assign pkt_id           = pkt_id_q;
  assign hash_num         = hash_q;
  assign num_processed    = nproc_q;

endmodule
